// File: rtl/deser_pkg.sv
// Shared types and constants for the serial deserializer slice.
package deser_pkg;

    localparam int DESER_WIDTH = 16;

    typedef enum logic {IDLE, SHIFT} deser_state_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// Bundle of the serial link, handshake and parallel word signals of the deserializer.
// The master side drives the link and ack; the slave side is the deserializer itself.
interface serial_deserializer_if #(parameter int WIDTH = deser_pkg::DESER_WIDTH);

    logic             start;
    logic             serial_in;
    logic             ack;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic             overrun;

    modport master (
        output start, serial_in, ack,
        input  data_out, valid, busy, overrun
    );

    modport slave (
        input  start, serial_in, ack,
        output data_out, valid, busy, overrun
    );

endinterface

// File: rtl/deser_bit_counter.sv
// Bit position counter for a frame: clear, load-one and increment, with a flag at the last bit.
// clear has priority over load_one, which has priority over incr.
module deser_bit_counter #(
    parameter int WIDTH = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic load_one,
    input  logic incr,
    output logic terminal
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load_one) begin
            count_d = CW'(1);
        end else if (incr) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_deserializer.sv
// MSB-first serial-to-parallel receiver; a start strobe marks the first bit of each frame.
// Define DESER_HANDSHAKE_EN to hold valid until ack and to flag overrun on unacked frames.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    serial_deserializer_if.slave  bus
);

    deser_state_t     state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shifted;
    logic             cnt_clear, cnt_load_one, cnt_incr, cnt_terminal;

    deser_bit_counter #(.WIDTH(WIDTH)) u_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .load_one (cnt_load_one),
        .incr     (cnt_incr),
        .terminal (cnt_terminal)
    );

    assign shifted = {shreg_q[WIDTH-2:0], bus.serial_in};

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        data_d       = data_q;
        overrun_d    = overrun_q;
        cnt_clear    = 1'b0;
        cnt_load_one = 1'b0;
        cnt_incr     = 1'b0;
`ifdef DESER_HANDSHAKE_EN
        valid_d      = bus.ack ? 1'b0 : valid_q;
`else
        valid_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d      = shifted;
                    cnt_load_one = 1'b1;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                // A start inside a frame re-aligns on the current bit, even on the last-bit cycle.
                if (bus.start) begin
                    cnt_load_one = 1'b1;
                end else if (cnt_terminal) begin
                    data_d    = shifted;
                    valid_d   = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
`ifdef DESER_HANDSHAKE_EN
                    if (valid_q && !bus.ack) begin
                        overrun_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = (state_q == SHIFT);
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: framing, back-to-back, resync, reset mid-frame, handshake.
module tb_serial_deserializer;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   vld_cnt  = 0;
    int   busy_cnt = 0;
    int   last_vld = 0;
    int   prev_vld = 0;
    int   v0, b0;

    serial_deserializer_if #(.WIDTH(16)) bus_if ();

    serial_deserializer #(.WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus_if.valid) begin
            vld_cnt  = vld_cnt + 1;
            prev_vld = last_vld;
            last_vld = cyc;
        end
        if (bus_if.busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic b);
        bus_if.start     = s;
        bus_if.serial_in = b;
        step();
    endtask

    // First n bits of w, MSB first, with start on the first of them.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) drive(i == 0, w[15-i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1);
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.serial_in = 1'b0;
        bus_if.ack       = 1'b1;
        step();
        step();
        check_eq("rst_data", bus_if.data_out, 16'h0000);
        check_eq("rst_valid", bus_if.valid, 1'b0);
        check_eq("rst_busy", bus_if.busy, 1'b0);
        check_eq("rst_overrun", bus_if.overrun, 1'b0);
        reset = 1'b0;

        idle(3);
        check_eq("idle_busy", bus_if.busy, 1'b0);
        check_eq("idle_valid", bus_if.valid, 1'b0);

        // Single frame
        v0 = vld_cnt;
        b0 = busy_cnt;
        send_bits(16'h3380, 16);
        check_eq("f1_valid", bus_if.valid, 1'b1);
        check_eq("f1_data", bus_if.data_out, 16'h3380);
        check_eq("f1_busy_after", bus_if.busy, 1'b0);
        check_eq("f1_busy_cycles", busy_cnt - b0, 15);
        idle(1);
        check_eq("f1_valid_pulse", bus_if.valid, 1'b0);
        check_eq("f1_data_hold", bus_if.data_out, 16'h3380);
        check_eq("f1_events", vld_cnt - v0, 1);

        // Back-to-back frames
        v0 = vld_cnt;
        send_bits(16'h3380, 16);
        check_eq("b2b_first", bus_if.data_out, 16'h3380);
        send_bits(16'hA5F0, 16);
        check_eq("b2b_second", bus_if.data_out, 16'hA5F0);
        check_eq("b2b_valid", bus_if.valid, 1'b1);
        idle(1);
        check_eq("b2b_events", vld_cnt - v0, 2);
        check_eq("b2b_spacing", last_vld - prev_vld, 16);
        check_eq("b2b_overrun", bus_if.overrun, 1'b0);

        // Resync after 7 bits
        v0 = vld_cnt;
        send_bits(16'hDEAD, 7);
        check_eq("rs7_busy", bus_if.busy, 1'b1);
        send_bits(16'h00FF, 16);
        check_eq("rs7_data", bus_if.data_out, 16'h00FF);
        idle(1);
        check_eq("rs7_events", vld_cnt - v0, 1);

        // Resync on the last-bit cycle
        v0 = vld_cnt;
        send_bits(16'hFFFF, 15);
        send_bits(16'hC3C3, 1);
        check_eq("rs15_no_valid", bus_if.valid, 1'b0);
        check_eq("rs15_data_hold", bus_if.data_out, 16'h00FF);
        send_bits(16'hC3C3, 16);
        check_eq("rs15_data", bus_if.data_out, 16'hC3C3);
        idle(1);
        check_eq("rs15_events", vld_cnt - v0, 1);

        // Reset mid-frame
        send_bits(16'hABCD, 9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mrst_busy", bus_if.busy, 1'b0);
        check_eq("mrst_data", bus_if.data_out, 16'h0000);
        v0 = vld_cnt;
        send_bits(16'h1234, 16);
        check_eq("mrst_frame", bus_if.data_out, 16'h1234);
        idle(1);
        check_eq("mrst_events", vld_cnt - v0, 1);

`ifdef DESER_HANDSHAKE_EN
        // Unacked frames overrun; ack clears valid but not overrun
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus_if.ack = 1'b0;
        send_bits(16'h3380, 16);
        idle(2);
        check_eq("hs_valid_held", bus_if.valid, 1'b1);
        check_eq("hs_no_overrun", bus_if.overrun, 1'b0);
        send_bits(16'hA5F0, 16);
        check_eq("hs_overrun", bus_if.overrun, 1'b1);
        check_eq("hs_data", bus_if.data_out, 16'hA5F0);
        check_eq("hs_valid", bus_if.valid, 1'b1);
        bus_if.ack = 1'b1;
        idle(1);
        bus_if.ack = 1'b0;
        check_eq("hs_ack_valid", bus_if.valid, 1'b0);
        check_eq("hs_ack_overrun", bus_if.overrun, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
